// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: one write port, two read ports, clear request and ready.
interface regfile_2r1w_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en_a;
  logic                  rd_en_b;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  rd_valid_a;
  logic                  rd_valid_b;
  logic                  clear;
  logic                  ready;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, clear,
    input  rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, clear,
    output rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, ready
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with a zeroing sweep after reset or clear.
// Define REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module regfile_2r1w #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_2r1w_if.slave      bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] clr_cnt, next_cnt;
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic run;
  logic wr_fire;
  logic rd_fire_a, rd_fire_b;
  logic fwd_a, fwd_b;

  // A clear in RUN takes priority and swallows any same-edge access.
  assign run       = (state == RUN);
  assign wr_fire   = run && !bus.clear && bus.wr_en;
  assign rd_fire_a = run && !bus.clear && bus.rd_en_a;
  assign rd_fire_b = run && !bus.clear && bus.rd_en_b;
  assign bus.ready = run;

`ifdef REGFILE_BYPASS_EN
  assign fwd_a = wr_fire && (bus.wr_addr == bus.rd_addr_a);
  assign fwd_b = wr_fire && (bus.wr_addr == bus.rd_addr_b);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= next_state;
      clr_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = clr_cnt;
    case (state)
      INIT: begin
        next_cnt = clr_cnt + 1'b1;
        if (clr_cnt == '1) next_state = RUN;
      end
      RUN: begin
        if (bus.clear) begin
          next_cnt   = '0;
          next_state = INIT;
        end
      end
      default: next_state = INIT;
    endcase
  end

  // Storage has no reset; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (state == INIT) regs[clr_cnt] <= '0;
    else if (wr_fire)  regs[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid_a <= 1'b0;
      bus.rd_valid_b <= 1'b0;
      bus.rd_data_a  <= '0;
      bus.rd_data_b  <= '0;
    end else begin
      bus.rd_valid_a <= rd_fire_a;
      bus.rd_valid_b <= rd_fire_b;
      if (rd_fire_a) bus.rd_data_a <= fwd_a ? bus.wr_data : regs[bus.rd_addr_a];
      if (rd_fire_b) bus.rd_data_b <= fwd_b ? bus.wr_data : regs[bus.rd_addr_b];
    end
  end
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w (16x16); expectations follow REGFILE_BYPASS_EN if defined.
module tb_regfile_2r1w;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] mdl [16];
  logic [15:0] exp_a;

  regfile_2r1w_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

  regfile_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en_a = 1'b0; bus.rd_en_b = 1'b0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    bus.clear = 1'b0;
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk({tag, "_ready"}, 32'(bus.ready), 32'(i == 16));
      chk({tag, "_valid_a"}, 32'(bus.rd_valid_a), 32'd0);
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'(i);
      bus.rd_en_b = 1'b1; bus.rd_addr_b = 4'(15 - i);
      step();
      chk({tag, "_data_a"}, 32'(bus.rd_data_a), 32'd0);
      chk({tag, "_data_b"}, 32'(bus.rd_data_b), 32'd0);
      chk({tag, "_valid_a"}, 32'(bus.rd_valid_a), 32'd1);
      chk({tag, "_valid_b"}, 32'(bus.rd_valid_b), 32'd1);
    end
    bus.rd_en_a = 1'b0; bus.rd_en_b = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    idle_inputs();

    // Reset state, asserted between edges
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_valid_a", 32'(bus.rd_valid_a), 32'd0);
    chk("rst_valid_b", 32'(bus.rd_valid_b), 32'd0);
    chk("rst_data_a", 32'(bus.rd_data_a), 32'd0);
    chk("rst_data_b", 32'(bus.rd_data_b), 32'd0);
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check("sweep0");
    read_all_zero("zero0");

    // Write 0xBEEF to 3, dual read next edge
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'hBEEF;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'd3;
    bus.rd_en_b = 1'b1; bus.rd_addr_b = 4'd3;
    step();
    chk("beef_a", 32'(bus.rd_data_a), 32'h0000_BEEF);
    chk("beef_b", 32'(bus.rd_data_b), 32'h0000_BEEF);
    chk("beef_va", 32'(bus.rd_valid_a), 32'd1);
    chk("beef_vb", 32'(bus.rd_valid_b), 32'd1);
    bus.rd_en_a = 1'b0; bus.rd_en_b = 1'b0;
    step();
    chk("hold_va", 32'(bus.rd_valid_a), 32'd0);
    chk("hold_vb", 32'(bus.rd_valid_b), 32'd0);
    chk("hold_a", 32'(bus.rd_data_a), 32'h0000_BEEF);

    // Same-edge write/read of address 5
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'h1234;
    bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'd5;
    step();
    chk("same_edge_a", 32'(bus.rd_data_a), BYPASS ? 32'h0000_1234 : 32'h0000_0000);
    bus.wr_en = 1'b0;
    step();
    chk("after_edge_a", 32'(bus.rd_data_a), 32'h0000_1234);
    bus.rd_en_a = 1'b0;

    // Fill, then clear with accesses held active through the sweep
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = 16'hA000 + 16'(i);
      step();
    end
    bus.wr_en = 1'b0;
    bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'd9;
    step();
    chk("fill_a9", 32'(bus.rd_data_a), 32'h0000_A009);
    bus.clear = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 16'hFFFF;
    bus.rd_en_a = 1'b1; bus.rd_en_b = 1'b1;
    step();
    chk("clr_ready", 32'(bus.ready), 32'd0);
    chk("clr_valid_a", 32'(bus.rd_valid_a), 32'd0);
    chk("clr_valid_b", 32'(bus.rd_valid_b), 32'd0);
    sweep_check("sweep1");
    idle_inputs();
    read_all_zero("zero1");

    // Reset in the middle of a sweep (clr_cnt = 7)
    bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 16'h5A5A;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'd9;
    bus.rd_en_b = 1'b1; bus.rd_addr_b = 4'd9;
    step();
    chk("pre_rst_a", 32'(bus.rd_data_a), 32'h0000_5A5A);
    bus.rd_en_a = 1'b0; bus.rd_en_b = 1'b0;
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_ready", 32'(bus.ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 32'd0);
    chk("mid_rst_va", 32'(bus.rd_valid_a), 32'd0);
    chk("mid_rst_vb", 32'(bus.rd_valid_b), 32'd0);
    chk("mid_rst_a", 32'(bus.rd_data_a), 32'd0);
    chk("mid_rst_b", 32'(bus.rd_data_b), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check("sweep2");
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    // Streaming reads 0..15 while writing 15..0
    for (int i = 0; i < 16; i++) begin
      bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'(i);
      bus.wr_en = 1'b1; bus.wr_addr = 4'(15 - i); bus.wr_data = 16'hC000 + 16'(i);
      exp_a = (BYPASS && (15 - i) == i) ? (16'hC000 + 16'(i)) : mdl[i];
      step();
      mdl[15 - i] = 16'hC000 + 16'(i);
      chk("stream_valid", 32'(bus.rd_valid_a), 32'd1);
      chk("stream_data", 32'(bus.rd_data_a), 32'(exp_a));
    end
    idle_inputs();
    step();
    chk("stream_end_valid", 32'(bus.rd_valid_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port wr_en, input, 1, write request.
REQ-006 SHALL have port wr_addr, input, ADDR_WIDTH, write address.
REQ-007 SHALL have port wr_data, input, DATA_WIDTH, write data.
REQ-008 SHALL have ports rd_en_a and rd_en_b, input, 1 each, read requests for ports A and B.
REQ-009 SHALL have ports rd_addr_a and rd_addr_b, input, ADDR_WIDTH each, read addresses.
REQ-010 SHALL have ports rd_data_a and rd_data_b, output, DATA_WIDTH each, registered read data.
REQ-011 SHALL have ports rd_valid_a and rd_valid_b, output, 1 each, one-cycle pulse marking new rd_data.
REQ-012 SHALL have port clear, input, 1, request to zero all registers.
REQ-013 SHALL have port ready, output, 1; high when the file accepts reads and writes.

Function
REQ-014 SHALL implement a two-state machine: INIT (clearing) and RUN; ready = 1 exactly in RUN.
REQ-015 In INIT, each rising edge SHALL write zero to the register at clr_cnt, then increment clr_cnt.
REQ-016 On the edge that clears address DEPTH-1, the block SHALL enter RUN; ready rises after exactly DEPTH edges in INIT.
REQ-017 In RUN, clear = 1 at an edge SHALL reset clr_cnt to 0 and enter INIT; wr_en and rd_en sampled on that same edge SHALL be ignored.
REQ-018 In INIT, clear, wr_en, rd_en_a and rd_en_b SHALL be ignored; rd_valid_a and rd_valid_b stay 0.
REQ-019 In RUN, wr_en = 1 SHALL write wr_data to registers[wr_addr] at the edge.
REQ-020 In RUN, rd_en_x = 1 at edge N SHALL load rd_data_x with registers[rd_addr_x] and pulse rd_valid_x high for the cycle after edge N (latency 1).
REQ-021 When rd_en_x = 0, rd_data_x SHALL hold its last value and rd_valid_x SHALL be 0.
REQ-022 Ports A and B SHALL operate independently, including reads of the same address in the same cycle.
REQ-023 Back-to-back reads SHALL be supported every cycle on both ports, with no bubbles.
REQ-024 A read and a write to the same address at the same edge SHALL follow REQ-034 and REQ-035.
REQ-025 Addresses SHALL be used unmodified; every value 0..DEPTH-1 is legal, with no wrap or range check.

Reset
REQ-026 rst_n low SHALL immediately force state to INIT, clr_cnt to 0, ready to 0, rd_valid_a and rd_valid_b to 0, and rd_data_a and rd_data_b to 0.
REQ-027 Register storage SHALL NOT be asynchronously reset; it is zeroed by the INIT sweep after rst_n deasserts.
REQ-028 rst_n asserted during INIT or RUN SHALL abort all activity and restart the sweep from address 0 after release.
REQ-029 No write from before reset SHALL be observable after ready rises; all registers read as 0.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-031 With REGFILE_BYPASS_EN defined, a read at edge N of an address written at edge N SHALL return the new wr_data.
REQ-032 Without REGFILE_BYPASS_EN, that read SHALL return the value stored before edge N; the new value is visible from edge N+1.
REQ-033 Write behaviour, latency and ready timing SHALL be identical in both builds.
REQ-034 (Same-edge rule, bypass build) The read port SHALL output the written value.
REQ-035 (Same-edge rule, non-bypass build) The read port SHALL output the old value.

Verification
REQ-036 Reset, then release rst_n with DATA_WIDTH=16, ADDR_WIDTH=4 -> ready = 0 for 16 edges, then 1; a read of every address returns 0x0000.
REQ-037 Write 0xBEEF to address 3, then read A at 3 and B at 3 at the next edge -> both rd_data = 0xBEEF, both rd_valid pulse 1 cycle later.
REQ-038 Same edge: write 0x1234 to address 5 and read A at 5 -> rd_data_a = 0x1234 in the bypass build, prior value (0x0000) in the non-bypass build.
REQ-039 Fill registers, assert clear for 1 cycle -> ready low 16 cycles, wr_en and rd_en ignored meanwhile, then all registers read 0x0000.
REQ-040 Assert rst_n low mid-sweep (clr_cnt = 7) -> outputs 0 immediately; after release ready rises after exactly 16 edges.
REQ-041 Read A every cycle with addresses 0..15 while writing 15..0 -> rd_valid_a continuous and data matches the model for the configured bypass mode.
